sap_mem_loader: RTL

// - Owns the SAP 16x8 program RAM during load. Sequences host bytes into memory

---
 rtl/sap_mem_loader.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sap_mem_loader.sv
// SAP program-RAM loader: streams host bytes into the 16x8 RAM while holding the CPU in reset.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running modulo-2^DATA_W sum of written bytes.
module sap_mem_loader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int WR_PULSE = 2,
    parameter int RES_CYC  = 3
) (
    input  logic              clk,
    input  logic              low_res,
    input  logic              prog_mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              low_mem_we,
    output logic              cpu_hold,
    output logic              low_cpu_res,
    output logic              load_done,
    output logic [ADDR_W:0]   load_cnt,
`ifdef LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [2:0]        dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = (WR_PULSE > 1) ? $clog2(WR_PULSE + 1) : 1;
    localparam int RW    = (RES_CYC > 1) ? $clog2(RES_CYC + 1) : 1;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    // Stream handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1;
    // in_ready is only raised in WAIT, so the host may hold in_valid and change in_data after a transfer.
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        ARM     = 3'd1,
        WAIT    = 3'd2,
        WRITE   = 3'd3,
        FULL    = 3'd4,
        RELEASE = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [RW-1:0]       rel_cnt_q, rel_cnt_d;
    logic [PW-1:0]       pulse_cnt_q, pulse_cnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     load_cnt_q, load_cnt_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                low_mem_we_q, low_mem_we_d;
    logic                in_ready_q, in_ready_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                low_cpu_res_q, low_cpu_res_d;
    logic                load_done_q, load_done_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif

    always_ff @(posedge clk or negedge low_res) begin
        if (!low_res) begin
            state_q       <= RELEASE;
            rel_cnt_q     <= RW'(RES_CYC);
            pulse_cnt_q   <= '0;
            wr_ptr_q      <= '0;
            load_cnt_q    <= '0;
            mem_wdata_q   <= '0;
            low_mem_we_q  <= 1'b1;
            in_ready_q    <= 1'b0;
            cpu_hold_q    <= 1'b1;
            low_cpu_res_q <= 1'b0;
            load_done_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rel_cnt_q     <= rel_cnt_d;
            pulse_cnt_q   <= pulse_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            load_cnt_q    <= load_cnt_d;
            mem_wdata_q   <= mem_wdata_d;
            low_mem_we_q  <= low_mem_we_d;
            in_ready_q    <= in_ready_d;
            cpu_hold_q    <= cpu_hold_d;
            low_cpu_res_q <= low_cpu_res_d;
            load_done_q   <= load_done_d;
`ifdef LOADER_CHECKSUM_EN
            checksum_q    <= checksum_d;
`endif
        end
    end

    // Registered outputs are computed as the values they must carry in the next state.
    always_comb begin
        state_d       = state_q;
        rel_cnt_d     = rel_cnt_q;
        pulse_cnt_d   = pulse_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        load_cnt_d    = load_cnt_q;
        mem_wdata_d   = mem_wdata_q;
        low_mem_we_d  = low_mem_we_q;
        in_ready_d    = in_ready_q;
        cpu_hold_d    = cpu_hold_q;
        low_cpu_res_d = low_cpu_res_q;
        load_done_d   = load_done_q;
`ifdef LOADER_CHECKSUM_EN
        checksum_d    = checksum_q;
`endif
        case (state_q)
            RUN: begin
                if (prog_mode) begin
                    state_d       = ARM;
                    cpu_hold_d    = 1'b1;
                    low_cpu_res_d = 1'b0;
                end
            end
            ARM: begin
                wr_ptr_d    = '0;
                load_cnt_d  = '0;
                load_done_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                checksum_d  = '0;
`endif
                in_ready_d  = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                // An accepted byte always gets written, even if prog_mode drops on the same edge.
                if (in_valid && in_ready_q) begin
                    mem_wdata_d  = in_data;
                    low_mem_we_d = 1'b0;
                    in_ready_d   = 1'b0;
                    pulse_cnt_d  = PW'(WR_PULSE - 1);
                    state_d      = WRITE;
                end else if (!prog_mode) begin
                    in_ready_d = 1'b0;
                    rel_cnt_d  = RW'(RES_CYC);
                    state_d    = RELEASE;
                end
            end
            WRITE: begin
                if (pulse_cnt_q == '0) begin
                    low_mem_we_d = 1'b1;
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    load_cnt_d   = load_cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    checksum_d   = checksum_q + mem_wdata_q;
`endif
                    if (load_cnt_q == LAST_CNT) begin
                        load_done_d = 1'b1;
                        state_d     = FULL;
                    end else if (!prog_mode) begin
                        rel_cnt_d = RW'(RES_CYC);
                        state_d   = RELEASE;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = WAIT;
                    end
                end else begin
                    pulse_cnt_d = pulse_cnt_q - 1'b1;
                end
            end
            FULL: begin
                if (!prog_mode) begin
                    rel_cnt_d = RW'(RES_CYC);
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                cpu_hold_d    = 1'b1;
                low_cpu_res_d = 1'b0;
                if (rel_cnt_q <= RW'(1)) begin
                    cpu_hold_d    = 1'b0;
                    low_cpu_res_d = 1'b1;
                    state_d       = RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q - 1'b1;
                end
            end
            default: begin
                low_mem_we_d  = 1'b1;
                in_ready_d    = 1'b0;
                cpu_hold_d    = 1'b1;
                low_cpu_res_d = 1'b0;
                rel_cnt_d     = RW'(RES_CYC);
                state_d       = RELEASE;
            end
        endcase
    end

    assign mem_addr    = (state_q == RUN) ? cpu_addr : wr_ptr_q;
    assign mem_wdata   = mem_wdata_q;
    assign low_mem_we  = low_mem_we_q;
    assign in_ready    = in_ready_q;
    assign cpu_hold    = cpu_hold_q;
    assign low_cpu_res = low_cpu_res_q;
    assign load_done   = load_done_q;
    assign load_cnt    = load_cnt_q;
    assign dbg_state   = state_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum    = checksum_q;
`endif

endmodule
